ifetch_ctrl: RTL and testbench
==============================

# ifetch_ctrl

Instruction-fetch controller for the RISC-V core. It owns the instruction memory port: first a loader writes the program into memory, then it sequences the PC, fetches one word per cycle and hands instructions to decode over a valid/ready handshake. It also handles branch/jump redirects and latches a fault on an illegal fetch address. It sits between the word-addressed instruction memory (read index = byte address >> 2, combinational read) and the decode stage.

## Interface

- RESET_PC, 32'h0000_0000, first fetch address after load completes
- MEM_WORDS, 1024, number of 32-bit words in instruction memory; legal byte addresses are 0 .. 4*MEM_WORDS-4

- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- load_en  in  1  level; 1 = hold core in program-load mode
- load_valid  in  1  loader write strobe, one word per cycle
- load_addr  in  32  loader byte address
- load_data  in  32  loader write data
- imem_addr  out  32  byte address to instruction memory
- imem_we  out  1  memory write enable
- imem_wdata  out  32  memory write data (= load_data)
- imem_rdata  in  32  combinational read data for imem_addr
- redirect_valid  in  1  branch/jump taken, one-cycle pulse
- redirect_pc  in  32  redirect target byte address
- inst_valid  out  1  inst/inst_pc hold a valid instruction
- inst_ready  in  1  decode accepts the instruction this cycle
- inst  out  32  fetched instruction
- inst_pc  out  32  byte address of inst
- fault  out  1  sticky illegal-fetch flag
- load_count  out  16  number of words written in the current load session

## Operation

- States: IDLE, LOAD, FETCH, HALT. Reset → IDLE.
- IDLE → LOAD if load_en = 1, otherwise → FETCH. On entry to LOAD, load_count is cleared to 0. On entry to FETCH, pc = RESET_PC.
- LOAD:
  - imem_addr = load_addr.
  - imem_we = load_valid & (load_addr[1:0] = 0) & (load_addr < 4*MEM_WORDS).
  - Each accepted write increments load_count, saturating at 16'hFFFF. Rejected writes are dropped silently.
  - load_en = 0 → FETCH, pc = RESET_PC, inst_valid = 0.
- FETCH:
  - imem_addr = pc, imem_we = 0.
  - Capture condition: (!inst_valid | inst_ready) & !redirect_valid. On capture: inst ← imem_rdata, inst_pc ← pc, inst_valid ← 1, pc ← pc+4 (32-bit wrap, no carry out).
  - If inst_valid & !inst_ready: inst, inst_pc, inst_valid and pc hold.
  - If nothing is captured and inst_ready = 1: inst_valid ← 0.
  - redirect_valid has priority over capture and stall: pc ← redirect_pc and inst_valid ← 0, even when inst_ready = 0, because the held instruction is squashed.
  - If an illegal pc (misaligned or ≥ 4*MEM_WORDS) would be captured, or an illegal redirect_pc is received → HALT. fault ← 1, inst_valid ← 0, no capture.
  - load_en = 1 → LOAD, inst_valid ← 0, load_count ← 0.
- HALT: inst_valid = 0, fault = 1. Only rst_n leaves this state; load_en, redirect_valid and load_valid are ignored.
- Reset values: state IDLE, pc = RESET_PC, inst_valid 0, inst 0, inst_pc 0, fault 0, load_count 0. imem_we is 0 and imem_addr = RESET_PC.

## Timing

- Memory read is combinational, so fetch latency is 1 cycle: the pc presented in cycle N appears on inst/inst_valid in cycle N+1.
- Throughput is 1 instruction per cycle while inst_ready = 1.
- After rst_n rises with load_en = 0: edge 1 IDLE→FETCH, edge 2 first capture. inst_valid = 1 after edge 2 with inst_pc = RESET_PC.
- Redirect costs exactly one bubble cycle: the redirect edge clears inst_valid, and the next edge captures mem[redirect_pc].
- A loader write occurs on the same edge as load_valid. load_count updates on that edge.
- Deasserting load_en: the next edge enters FETCH, and the edge after that makes the first instruction valid.
- Asserting rst_n mid-LOAD or mid-FETCH clears all state immediately. A write in flight is not performed when rst_n is low.

## Test plan

- Load then run: load_en = 1, write 0x00500093, 0x00100113, 0x002081B3, 0x00000013 at byte addresses 0, 4, 8, 12; drop load_en; inst_ready = 1 → load_count = 4; inst/inst_pc = (0x00500093, 0), (0x00100113, 4), (0x002081B3, 8), (0x00000013, 12) on consecutive cycles.
- Backpressure: hold inst_ready = 0 for 3 cycles while inst_pc = 4 → inst, inst_pc and inst_valid are stable for those 3 cycles; release → next inst_pc = 8, with no skipped or duplicated PC.
- Redirect during stall: inst_ready = 0 with inst_pc = 8, pulse redirect_valid with redirect_pc = 0x20 → next cycle inst_valid = 0; following cycle inst_pc = 0x20 and inst = mem[8].
- Illegal redirect: redirect_pc = 0x22 → fault = 1 and inst_valid = 0, held for 10 cycles while toggling load_en and redirect_valid. Only rst_n clears fault.
- Run-off end: MEM_WORDS = 4, run past pc = 12 → the fetch at pc = 16 does not produce inst_valid, and fault = 1.
- Loader filtering and reset: writes to 0x2 and 0x1000 (MEM_WORDS = 1024) → imem_we = 0 and load_count unchanged. Assert rst_n low mid-load → load_count = 0 and state IDLE immediately; a write strobed while rst_n is low does not modify memory.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch controller.
// Owns the instruction memory port: program load, PC sequencing, one-word-per-cycle
// fetch with a valid/ready handoff to decode, redirects and a sticky fault on an
// illegal fetch address.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic        load_valid,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic [31:0] imem_addr,
    output logic        imem_we,
    output logic [31:0] imem_wdata,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fault,
    output logic [15:0] load_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FETCH,
        HALT
    } state_t;

    // One past the last legal byte address; 33 bits so the bound cannot wrap.
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic        fault_q, fault_d;
    logic [15:0] load_count_q, load_count_d;

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ({1'b0, a} < ADDR_LIMIT);
    endfunction

    // Memory port: the loader drives it in LOAD, the PC drives it otherwise.
    always_comb begin
        imem_addr  = (state_q == LOAD) ? load_addr : pc_q;
        imem_we    = (state_q == LOAD) && load_valid && addr_ok(load_addr);
        imem_wdata = load_data;
    end

    // Next-state and datapath update for all four states.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        fault_d      = fault_q;
        load_count_d = load_count_q;

        case (state_q)
            IDLE: begin
                if (load_en) begin
                    state_d      = LOAD;
                    load_count_d = '0;
                end else begin
                    state_d = FETCH;
                    pc_d    = RESET_PC;
                end
            end

            LOAD: begin
                if (imem_we && (load_count_q != '1)) begin
                    load_count_d = load_count_q + 16'd1;
                end
                if (!load_en) begin
                    state_d      = FETCH;
                    pc_d         = RESET_PC;
                    inst_valid_d = 1'b0;
                end
            end

            FETCH: begin
                // Leaving for a new load wins; then a redirect squashes any
                // held instruction; otherwise capture whenever the slot is free.
                if (load_en) begin
                    state_d      = LOAD;
                    inst_valid_d = 1'b0;
                    load_count_d = '0;
                end else if (redirect_valid) begin
                    inst_valid_d = 1'b0;
                    if (addr_ok(redirect_pc)) begin
                        pc_d = redirect_pc;
                    end else begin
                        state_d = HALT;
                        fault_d = 1'b1;
                    end
                end else if (!inst_valid_q || inst_ready) begin
                    if (addr_ok(pc_q)) begin
                        inst_d       = imem_rdata;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_q + 32'd4;
                    end else begin
                        state_d      = HALT;
                        fault_d      = 1'b1;
                        inst_valid_d = 1'b0;
                    end
                end
            end

            HALT: begin
                inst_valid_d = 1'b0;
                fault_d      = 1'b1;
            end

            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            load_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            fault_q      <= fault_d;
            load_count_q <= load_count_d;
        end
    end

    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;
    assign fault      = fault_q;
    assign load_count = load_count_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: a 1024-word instance checked every cycle against a
// behavioural model, and a 4-word instance for the run-off-the-end case.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst4_n = 1'b0;
    logic        load_en = 1'b1;
    logic        load_valid = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_ready = 1'b0;

    logic [31:0] imem_addr, imem_wdata, imem_rdata, inst, inst_pc;
    logic        imem_we, inst_valid, fault;
    logic [15:0] load_count;

    logic [31:0] imem_addr4, imem_wdata4, imem_rdata4, inst4, inst_pc4;
    logic        imem_we4, inst_valid4, fault4;
    logic [15:0] load_count4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ifetch_ctrl #(.RESET_PC(32'h0), .MEM_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_valid(load_valid),
        .load_addr(load_addr), .load_data(load_data), .imem_addr(imem_addr),
        .imem_we(imem_we), .imem_wdata(imem_wdata), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .fault(fault), .load_count(load_count)
    );

    ifetch_ctrl #(.RESET_PC(32'h0), .MEM_WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .load_en(load_en), .load_valid(load_valid),
        .load_addr(load_addr), .load_data(load_data), .imem_addr(imem_addr4),
        .imem_we(imem_we4), .imem_wdata(imem_wdata4), .imem_rdata(imem_rdata4),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid4), .inst_ready(inst_ready), .inst(inst4),
        .inst_pc(inst_pc4), .fault(fault4), .load_count(load_count4)
    );

    // Background memory contents: unwritten word i reads as A000_0000 + i.
    function automatic logic [31:0] bg_word(input int unsigned idx);
        return 32'hA000_0000 + 32'(idx);
    endfunction

    // Environment memories (write on the clock edge, combinational read).
    logic [31:0] mem [1024];
    bit   [1023:0] wr;
    logic [31:0] mem4 [4];

    always @(posedge clk) begin
        if (imem_we) begin
            mem[imem_addr[11:2]] <= imem_wdata;
            wr[imem_addr[11:2]]  <= 1'b1;
        end
        if (imem_we4) mem4[imem_addr4[3:2]] <= imem_wdata4;
    end

    assign imem_rdata  = (imem_addr < 32'd4096) ?
                         (wr[imem_addr[11:2]] ? mem[imem_addr[11:2]] : bg_word(int'(imem_addr[11:2]))) : '0;
    assign imem_rdata4 = (imem_addr4 < 32'd16) ? mem4[imem_addr4[3:2]] : '0;

    // ---------------- behavioural model of the 1024-word instance ----------------
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HALT = 3;
    int          m_mode  = M_IDLE;
    logic [31:0] m_pc    = '0;
    logic        m_v     = 1'b0;
    logic [31:0] m_inst  = '0;
    logic [31:0] m_ipc   = '0;
    logic        m_fault = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] m_mem [1024];
    bit   [1023:0] m_wr;

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < 32'd4096);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int unsigned idx;
        idx = a / 4;
        return m_wr[idx] ? m_mem[idx] : bg_word(idx);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_IDLE; m_pc <= '0; m_v <= 1'b0; m_inst <= '0;
            m_ipc <= '0; m_fault <= 1'b0; m_cnt <= 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (load_en) begin m_mode <= M_LOAD; m_cnt <= 0; end
                    else begin m_mode <= M_RUN; m_pc <= '0; end
                end
                M_LOAD: begin
                    if (load_valid && legal(load_addr)) begin
                        m_mem[load_addr / 4] <= load_data;
                        m_wr[load_addr / 4]  <= 1'b1;
                        m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
                    end
                    if (!load_en) begin m_mode <= M_RUN; m_pc <= '0; m_v <= 1'b0; end
                end
                M_RUN: begin
                    if (load_en) begin
                        m_mode <= M_LOAD; m_v <= 1'b0; m_cnt <= 0;
                    end else if (redirect_valid) begin
                        m_v <= 1'b0;
                        if (legal(redirect_pc)) m_pc <= redirect_pc;
                        else begin m_mode <= M_HALT; m_fault <= 1'b1; end
                    end else if (!m_v || inst_ready) begin
                        if (legal(m_pc)) begin
                            m_inst <= m_read(m_pc); m_ipc <= m_pc; m_v <= 1'b1;
                            m_pc <= m_pc + 32'd4;
                        end else begin
                            m_mode <= M_HALT; m_fault <= 1'b1; m_v <= 1'b0;
                        end
                    end
                end
                default: begin m_v <= 1'b0; m_fault <= 1'b1; end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    task automatic compare_model();
        logic        exp_we;
        logic [31:0] exp_addr;
        exp_we   = (m_mode == M_LOAD) && rst_n && load_valid && legal(load_addr);
        exp_addr = (m_mode == M_LOAD) ? load_addr : m_pc;
        check("model.inst_valid", 32'(inst_valid), 32'(m_v));
        check("model.fault", 32'(fault), 32'(m_fault));
        check("model.load_count", 32'(load_count), 32'(m_cnt));
        check("model.imem_we", 32'(imem_we), 32'(exp_we));
        check("model.imem_addr", imem_addr, exp_addr);
        if (m_v) begin
            check("model.inst", inst, m_inst);
            check("model.inst_pc", inst_pc, m_ipc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_model();
    endtask

    logic [31:0] prog [4];

    initial begin
        prog[0] = 32'h00500093; prog[1] = 32'h00100113;
        prog[2] = 32'h002081B3; prog[3] = 32'h00000013;

        // ---- run-off end on the 4-word instance (main instance held in reset) ----
        step();
        rst4_n = 1'b1;
        step();                                  // IDLE -> LOAD
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1; load_addr = 32'(i * 4); load_data = prog[i];
            step();
        end
        load_valid = 1'b0;
        check("w4.load_count", 32'(load_count4), 32'd4);
        load_en = 1'b0;
        step();                                  // -> FETCH
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("w4.inst", inst4, prog[i]);
            check("w4.inst_pc", inst_pc4, 32'(i * 4));
        end
        step();                                  // fetch at pc 16 is illegal
        check("w4.runoff_valid", 32'(inst_valid4), 32'd0);
        check("w4.runoff_fault", 32'(fault4), 32'd1);
        rst4_n = 1'b0;
        inst_ready = 1'b0;
        load_en = 1'b1;

        // ---- reset state of the main instance ----
        step();
        check("rst.inst_valid", 32'(inst_valid), 32'd0);
        check("rst.fault", 32'(fault), 32'd0);
        check("rst.load_count", 32'(load_count), 32'd0);
        check("rst.imem_addr", imem_addr, 32'h0);
        check("rst.imem_we", 32'(imem_we), 32'd0);

        // ---- load then run ----
        rst_n = 1'b1;
        step();                                  // IDLE -> LOAD
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1; load_addr = 32'(i * 4); load_data = prog[i];
            step();
        end
        load_valid = 1'b0;
        check("load.count", 32'(load_count), 32'd4);
        load_en = 1'b0;
        step();                                  // -> FETCH, no instruction yet
        check("run.bubble", 32'(inst_valid), 32'd0);
        inst_ready = 1'b1;
        step();
        check("run.inst0", inst, 32'h00500093);
        check("run.pc0", inst_pc, 32'h0);
        step();
        check("run.inst1", inst, 32'h00100113);
        check("run.pc1", inst_pc, 32'h4);

        // ---- backpressure at inst_pc = 4 ----
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp.valid", 32'(inst_valid), 32'd1);
            check("bp.inst", inst, 32'h00100113);
            check("bp.pc", inst_pc, 32'h4);
        end
        inst_ready = 1'b1;
        step();
        check("bp.release_pc", inst_pc, 32'h8);
        check("bp.release_inst", inst, 32'h002081B3);

        // ---- redirect during stall ----
        inst_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        step();
        redirect_valid = 1'b0;
        check("redir.bubble", 32'(inst_valid), 32'd0);
        step();
        check("redir.valid", 32'(inst_valid), 32'd1);
        check("redir.pc", inst_pc, 32'h20);
        check("redir.inst", inst, 32'hA000_0008);
        inst_ready = 1'b1;
        step();
        check("redir.next_pc", inst_pc, 32'h24);
        step();

        // ---- illegal redirect ----
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        step();
        check("illegal.fault", 32'(fault), 32'd1);
        check("illegal.valid", 32'(inst_valid), 32'd0);
        redirect_pc = 32'h0;
        for (int i = 0; i < 10; i++) begin
            load_en = i[0]; redirect_valid = ~i[0]; load_valid = i[1];
            step();
            check("halt.fault", 32'(fault), 32'd1);
            check("halt.valid", 32'(inst_valid), 32'd0);
        end
        redirect_valid = 1'b0; load_valid = 1'b0; load_en = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("halt.rst_fault", 32'(fault), 32'd0);

        // ---- loader filtering ----
        rst_n = 1'b1;
        step();                                  // IDLE -> LOAD
        load_valid = 1'b1; load_addr = 32'h2; load_data = 32'h1111_1111;
        #1 check("filt.we_misaligned", 32'(imem_we), 32'd0);
        step();
        check("filt.count_misaligned", 32'(load_count), 32'd0);
        load_addr = 32'h1000;
        #1 check("filt.we_range", 32'(imem_we), 32'd0);
        step();
        check("filt.count_range", 32'(load_count), 32'd0);
        load_addr = 32'h40; load_data = 32'h0000_1234;
        #1 check("filt.we_ok", 32'(imem_we), 32'd1);
        step();
        check("filt.count_ok", 32'(load_count), 32'd1);
        check("filt.mem16", mem[16], 32'h0000_1234);

        // ---- reset mid-load with a write strobed ----
        load_addr = 32'h44; load_data = 32'hDEAD_BEEF;
        #1 rst_n = 1'b0;
        #1 check("rstload.count", 32'(load_count), 32'd0);
        check("rstload.we", 32'(imem_we), 32'd0);
        check("rstload.addr", imem_addr, 32'h0);
        step();
        check("rstload.mem17_untouched", 32'(wr[17]), 32'd0);
        load_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
